// File: rtl/banner_pkg.sv
// Character codes, 7-segment glyph table and output polarity helper
// shared by the banner scroller and its decoder.
package banner_pkg;

    localparam int CHAR_W = 5;
    typedef logic [CHAR_W-1:0] char_t;

    localparam char_t CH_BLANK = 5'h10;
    localparam char_t CH_H     = 5'h11;
    localparam char_t CH_L     = 5'h12;
    localparam char_t CH_N     = 5'h13;
    localparam char_t CH_O     = 5'h14;
    localparam char_t CH_P     = 5'h15;
    localparam char_t CH_R     = 5'h16;
    localparam char_t CH_T     = 5'h17;
    localparam char_t CH_U     = 5'h18;
    localparam char_t CH_Y     = 5'h19;
    localparam char_t CH_DASH  = 5'h1A;
    localparam char_t CH_UNDER = 5'h1B;
    localparam char_t CH_J     = 5'h1C;
    localparam char_t CH_G     = 5'h1D;
    localparam char_t CH_DEG   = 5'h1E;
    localparam char_t CH_DOT   = 5'h1F;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7_of(char_t code);
        logic [6:0] s;
        case (code)
            5'h00:    s = 7'h3F;
            5'h01:    s = 7'h06;
            5'h02:    s = 7'h5B;
            5'h03:    s = 7'h4F;
            5'h04:    s = 7'h66;
            5'h05:    s = 7'h6D;
            5'h06:    s = 7'h7D;
            5'h07:    s = 7'h07;
            5'h08:    s = 7'h7F;
            5'h09:    s = 7'h6F;
            5'h0A:    s = 7'h77;
            5'h0B:    s = 7'h7C;
            5'h0C:    s = 7'h39;
            5'h0D:    s = 7'h5E;
            5'h0E:    s = 7'h79;
            5'h0F:    s = 7'h71;
            CH_H:     s = 7'h76;
            CH_L:     s = 7'h38;
            CH_N:     s = 7'h54;
            CH_O:     s = 7'h5C;
            CH_P:     s = 7'h73;
            CH_R:     s = 7'h50;
            CH_T:     s = 7'h78;
            CH_U:     s = 7'h3E;
            CH_Y:     s = 7'h6E;
            CH_DASH:  s = 7'h40;
            CH_UNDER: s = 7'h08;
            CH_J:     s = 7'h1E;
            CH_G:     s = 7'h3D;
            CH_DEG:   s = 7'h63;
            default:  s = 7'h00;
        endcase
        return s;
    endfunction

    function automatic logic dp_of(char_t code);
        return code == CH_DOT;
    endfunction

    function automatic logic [6:0] pol7(logic [6:0] v, bit active_low);
        return active_low ? ~v : v;
    endfunction

endpackage

// File: rtl/banner_scroller_if.sv
// System-side strobes, message write port and display outputs of the scroller.
interface banner_scroller_if #(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned MSG_LEN  = 16
);
    import banner_pkg::*;

    localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    logic                tick_display;
    logic                tick_banner;
    logic                scroll_en;
    logic                msg_wr_en;
    logic [AW-1:0]       msg_wr_addr;
    char_t               msg_wr_data;
    logic [N_DIGITS-1:0] an;
    logic [6:0]          seg;
    logic                dp;
    logic [AW-1:0]       scroll_pos;

    modport master (
        output tick_display, tick_banner, scroll_en, msg_wr_en, msg_wr_addr, msg_wr_data,
        input  an, seg, dp, scroll_pos
    );

    modport slave (
        input  tick_display, tick_banner, scroll_en, msg_wr_en, msg_wr_addr, msg_wr_data,
        output an, seg, dp, scroll_pos
    );

endinterface

// File: rtl/banner_scroller_seg7_decoder.sv
// Combinational character-code to active-high segment/dp decode.
module seg7_decoder
    import banner_pkg::*;
(
    input  char_t      code,
    output logic [6:0] seg,
    output logic       dp
);

    always_comb begin
        seg = seg7_of(code);
        dp  = dp_of(code);
    end

endmodule

// File: rtl/banner_scroller.sv
// Scrolling message banner on a multiplexed 7-segment display: edge-detected
// scan/scroll strobes, resettable message store, registered digit outputs.
module banner_scroller
    import banner_pkg::*;
#(
    parameter int unsigned N_DIGITS   = 4,
    parameter int unsigned MSG_LEN    = 16,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input logic             clk,
    input logic             rst,
    banner_scroller_if.slave bus
);

    localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]          SEG_OFF = {7{ACTIVE_LOW}};

    logic                tick_display_q, tick_display_d;
    logic                tick_banner_q,  tick_banner_d;
    logic [DW-1:0]       digit_sel_q,    digit_sel_d;
    logic [AW-1:0]       scroll_pos_q,   scroll_pos_d;
    char_t               mem_q [MSG_LEN];
    char_t               mem_d [MSG_LEN];
    logic [N_DIGITS-1:0] an_q,  an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q,  dp_d;

    logic                d_rise, b_rise;
    logic [AW:0]         char_sum;
    logic [AW-1:0]       char_idx;
    char_t               char_sel;
    logic [N_DIGITS-1:0] an_onehot;
    logic [6:0]          seg_raw;
    logic                dp_raw;

    seg7_decoder u_dec (
        .code (char_sel),
        .seg  (seg_raw),
        .dp   (dp_raw)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
        tick_display_d = bus.tick_display;
        tick_banner_d  = bus.tick_banner;
        d_rise         = bus.tick_display & ~tick_display_q;
        b_rise         = bus.tick_banner  & ~tick_banner_q;
        digit_sel_d    = digit_sel_q;
        scroll_pos_d   = scroll_pos_q;
        mem_d          = mem_q;
        an_d           = an_q;
        seg_d          = seg_q;
        dp_d           = dp_q;
        an_onehot      = '0;

        if (d_rise) begin
            digit_sel_d = (digit_sel_q == DW'(N_DIGITS - 1)) ? '0 : digit_sel_q + DW'(1);
        end
        if (b_rise && bus.scroll_en) begin
            scroll_pos_d = (scroll_pos_q == AW'(MSG_LEN - 1)) ? '0 : scroll_pos_q + AW'(1);
        end

        // Explicit wrap so non-power-of-two message lengths index correctly.
        char_sum = {1'b0, scroll_pos_d} + (AW + 1)'(digit_sel_d);
        if (char_sum >= (AW + 1)'(MSG_LEN)) begin
            char_sum = char_sum - (AW + 1)'(MSG_LEN);
        end
        char_idx = char_sum[AW-1:0];
        // Reads the store before this edge's write lands: a same-cycle write shows on the next visit.
        char_sel = mem_q[char_idx];

        an_onehot[digit_sel_d] = 1'b1;
        if (d_rise) begin
            an_d  = ACTIVE_LOW ? ~an_onehot : an_onehot;
            seg_d = pol7(seg_raw, ACTIVE_LOW);
            dp_d  = ACTIVE_LOW ? ~dp_raw : dp_raw;
        end

        if (bus.msg_wr_en && (32'(bus.msg_wr_addr) < MSG_LEN)) begin
            mem_d[bus.msg_wr_addr] = bus.msg_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignment so every flop samples the pre-edge values.
        if (rst) begin
            tick_display_q <= 1'b0;
            tick_banner_q  <= 1'b0;
            digit_sel_q    <= '0;
            scroll_pos_q   <= '0;
            an_q           <= AN_OFF;
            seg_q          <= SEG_OFF;
            dp_q           <= ACTIVE_LOW;
            // NOTE: the message must read blank straight out of reset, so the store is resettable flops, not a RAM macro.
            for (int i = 0; i < int'(MSG_LEN); i++) begin
                mem_q[i] <= CH_BLANK;
            end
        end else begin
            tick_display_q <= tick_display_d;
            tick_banner_q  <= tick_banner_d;
            digit_sel_q    <= digit_sel_d;
            scroll_pos_q   <= scroll_pos_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            mem_q          <= mem_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.scroll_pos = scroll_pos_q;

endmodule
